// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray pointer, level flags and a
// first-word-fall-through output register fed from the FIFO memory.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_rcv,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  err_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AE    = PW'(AE_THRESH);

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++)
      b[i] = ^(g >> i);
    return b;
  endfunction

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_nxt;
  logic [PW-1:0] wbin_sync;
  logic          load;
  logic          overflow;

  assign wbin_sync    = g2b(wptr_gray_sync);
  assign rd_count     = wbin_sync - rbin;
  assign empty        = (rptr_gray == wptr_gray_sync);
  assign almost_empty = (rd_count <= AE);
  assign overflow     = (rd_count > DEPTH);
  assign mem_raddr    = rbin[ADDR_WIDTH-1:0];
  assign rbin_nxt     = rbin + 1'b1;

  // Refill whenever the output slot is free or being drained this cycle.
  assign load    = (!rd_valid || rd_ready) && !empty;
  assign mem_ren = load && reset_n;

  always_ff @(posedge clk_rcv or negedge reset_n) begin
    if (!reset_n) begin
      rbin         <= '0;
      rptr_gray    <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (overflow)
        err_overflow <= 1'b1;
      if (load) begin
        rd_data   <= mem_rdata;
        rd_valid  <= 1'b1;
        rbin      <= rbin_nxt;
        rptr_gray <= rbin_nxt ^ (rbin_nxt >> 1);
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: integer FIFO model compared every cycle,
// scoreboard on delivered words, and literal directed checks.
module tb_fifo_rd_ctrl;

  logic       clk_rcv = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] wptr_gray_sync;
  logic [7:0] mem_rdata;
  logic       rd_ready = 1'b0;
  logic [3:0] mem_raddr;
  logic       mem_ren;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] rptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_count;
  logic       err_overflow;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AE_THRESH(2)) dut (
    .clk_rcv(clk_rcv), .reset_n(reset_n),
    .wptr_gray_sync(wptr_gray_sync), .mem_rdata(mem_rdata),
    .rd_ready(rd_ready), .mem_raddr(mem_raddr), .mem_ren(mem_ren),
    .rd_valid(rd_valid), .rd_data(rd_data), .rptr_gray(rptr_gray),
    .empty(empty), .almost_empty(almost_empty), .rd_count(rd_count),
    .err_overflow(err_overflow)
  );

  always #5 clk_rcv = ~clk_rcv;

  logic [7:0] mem [16];
  logic [4:0] wcount = '0;
  int         seq = 0;
  logic [7:0] exp_q [$];
  bit         sb_on = 1'b1;
  int         pops = 0;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wptr_gray_sync = gray(wcount);
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: integer count of words fetched and the output register.
  int         m_r = 0;
  bit         m_valid = 0;
  logic [7:0] m_data = '0;
  bit         m_err = 0;

  always @(posedge clk_rcv or negedge reset_n) begin
    int cnt;
    if (!reset_n) begin
      m_r = 0; m_valid = 0; m_data = '0; m_err = 0;
    end else begin
      cnt = (int'(wcount) - m_r) & 31;
      if (cnt > 16) m_err = 1;
      if ((!m_valid || rd_ready) && cnt != 0) begin
        m_data = mem[m_r % 16];
        m_valid = 1;
        m_r = (m_r + 1) % 32;
      end else if (m_valid && rd_ready) begin
        m_valid = 0;
      end
    end
  end

  logic [4:0] prev_g = '0;

  always @(negedge clk_rcv) begin
    int cnt;
    bit ren;
    cnt = (int'(wcount) - m_r) & 31;
    ren = reset_n && (!m_valid || rd_ready) && cnt != 0;
    chk("rd_count", rd_count, cnt);
    chk("empty", empty, int'(cnt == 0));
    chk("almost_empty", almost_empty, int'(cnt <= 2));
    chk("mem_raddr", mem_raddr, m_r % 16);
    chk("mem_ren", mem_ren, int'(ren));
    chk("rd_valid", rd_valid, int'(m_valid));
    if (m_valid) chk("rd_data", rd_data, m_data);
    chk("rptr_gray", rptr_gray, gray(5'(m_r)));
    chk("err_overflow", err_overflow, int'(m_err));
    if (reset_n && rptr_gray != prev_g)
      chk("gray_step_bits", $countones(rptr_gray ^ prev_g), 1);
    prev_g = rptr_gray;
    if (sb_on && reset_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_word", 1, 0);
      end else begin
        chk("sb_order", rd_data, exp_q.pop_front());
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_rcv);
    #2;
  endtask

  task automatic push_word();
    logic [7:0] d;
    d = 8'((seq * 37 + 11) & 255);
    seq++;
    mem[wcount[3:0]] = d;
    exp_q.push_back(d);
    wcount = wcount + 5'd1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) tick();
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_rptr_gray", rptr_gray, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Three words, consumer stalled
    repeat (3) push_word();
    #1;
    chk("first_ren", mem_ren, 1);
    chk("first_raddr", mem_raddr, 0);
    chk("first_count", rd_count, 3);
    tick();
    #1;
    chk("first_valid", rd_valid, 1);
    chk("first_data", rd_data, 8'd11);
    chk("stall_count", rd_count, 2);
    chk("stall_ae", almost_empty, 1);
    chk("stall_ren", mem_ren, 0);
    repeat (3) tick();
    chk("stall_hold_data", rd_data, 8'd11);

    // Fill to 16 total and stream at full rate
    repeat (13) push_word();
    rd_ready = 1'b1;
    repeat (16) tick();
    #1;
    chk("burst_pops", pops, 16);
    chk("burst_valid", rd_valid, 0);
    chk("burst_empty", empty, 1);
    chk("burst_gray16", rptr_gray, 5'b11000);

    // Next 16 words wrap the pointer, consumer throttled
    repeat (16) push_word();
    for (int i = 0; i < 40; i++) begin
      rd_ready = (i % 3) != 2;
      tick();
    end
    rd_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("wrap_pops", pops, 32);
    chk("wrap_gray0", rptr_gray, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_queue_left", exp_q.size(), 0);

    // Overflow: write pointer 17 ahead of rbin=0
    sb_on = 1'b0;
    wcount = 5'd17;
    #1;
    chk("ovf_count", rd_count, 17);
    chk("ovf_not_yet", err_overflow, 0);
    tick();
    #1;
    chk("ovf_set", err_overflow, 1);
    repeat (5) tick();
    #1;
    chk("ovf_sticky", err_overflow, 1);
    chk("mid_valid", rd_valid, 1);

    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_data", rd_data, 0);
    chk("arst_gray", rptr_gray, 0);
    chk("arst_err", err_overflow, 0);
    chk("arst_ren", mem_ren, 0);
    chk("arst_raddr", mem_raddr, 0);
    wcount = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    #1;
    chk("post_err", err_overflow, 0);
    chk("post_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, memory address width; FIFO depth is 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, word width.
REQ-003 Parameter AE_THRESH, default 2, almost-empty threshold in words.
REQ-004 clk_rcv  input  1  read-domain clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 wptr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray coded, already synchronized into clk_rcv.
REQ-007 mem_rdata  input  DATA_WIDTH  combinational read data of the FIFO memory at mem_raddr.
REQ-008 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 mem_raddr  output  ADDR_WIDTH  memory read address.
REQ-010 mem_ren  output  1  memory read strobe, one word fetched per asserted cycle.
REQ-011 rd_valid  output  1  rd_data holds a valid word (first-word-fall-through).
REQ-012 rd_data  output  DATA_WIDTH  registered output word.
REQ-013 rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, for synchronization into the write domain.
REQ-014 empty  output  1  no unfetched words in memory.
REQ-015 almost_empty  output  1  unfetched words <= AE_THRESH.
REQ-016 rd_count  output  ADDR_WIDTH+1  unfetched word count.
REQ-017 err_overflow  output  1  sticky protocol error flag.

Function
REQ-018 The block SHALL hold a binary read pointer rbin of ADDR_WIDTH+1 bits; mem_raddr SHALL equal rbin[ADDR_WIDTH-1:0] continuously.
REQ-019 wbin_sync SHALL be the Gray-to-binary conversion of wptr_gray_sync; rd_count SHALL equal (wbin_sync - rbin) modulo 2**(ADDR_WIDTH+1), combinationally.
REQ-020 empty SHALL be 1 exactly when rptr_gray == wptr_gray_sync; almost_empty SHALL be 1 when rd_count <= AE_THRESH.
REQ-021 load SHALL be (!rd_valid || rd_ready) && !empty; mem_ren SHALL equal load.
REQ-022 On a clock edge with load=1: rd_data <= mem_rdata, rd_valid <= 1, rbin <= rbin+1, rptr_gray <= bin2gray(rbin+1).
REQ-023 On a clock edge with rd_valid && rd_ready && empty: rd_valid <= 0 and rd_data SHALL hold its value.
REQ-024 With rd_valid=1 and rd_ready=0, rd_data, rd_valid and rbin SHALL hold (no overwrite of an unaccepted word).
REQ-025 Sustained throughput SHALL be one word per clk_rcv cycle while rd_ready=1 and empty=0; the first word SHALL appear on rd_valid one cycle after empty falls.
REQ-026 rbin and rptr_gray SHALL wrap from all-ones to zero; the wrap bit SHALL toggle on each pass through the memory.
REQ-027 rptr_gray SHALL change by exactly one bit per increment and SHALL be driven from a flop, with no combinational path.
REQ-028 wptr_gray_sync may advance several counts in one cycle; rd_count, empty and almost_empty SHALL follow within the same cycle.
REQ-029 If rd_count > 2**ADDR_WIDTH, err_overflow SHALL set on the next edge and stay set until reset; pointer behaviour is unchanged.
REQ-030 A simultaneous accept and refill (rd_valid && rd_ready && !empty) SHALL replace the word in the same edge without a bubble.

Reset
REQ-031 While reset_n=0: rbin=0, rptr_gray=0, rd_valid=0, rd_data=0, err_overflow=0, asynchronously.
REQ-032 While reset is asserted, mem_ren SHALL be 0.
REQ-033 On deassertion, operation SHALL start on the first clk_rcv edge.
REQ-034 Reset asserted mid-transfer SHALL discard the rd_data word.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, AE_THRESH=2)
REQ-035 Reset with wptr_gray_sync=0 -> empty=1, almost_empty=1, rd_count=0, rd_valid=0, mem_ren=0, rptr_gray=0.
REQ-036 Drive wptr_gray_sync to Gray(3), rd_ready=0 -> one mem_ren pulse at raddr 0; rd_valid=1 next cycle; rd_count=2; almost_empty=1; the block then stalls.
REQ-037 Drive wptr_gray_sync to Gray(16) after 16 words are loaded and hold rd_ready=1 -> 16 words are delivered in 16 consecutive cycles in address order; empty=1 at the end; rptr_gray=Gray(16)=5'b11000.
REQ-038 Continue 16 more words to Gray(0) -> rbin wraps from 31 to 0; each rptr_gray step changes exactly 1 bit; no word is lost or duplicated.
REQ-039 Drive wptr_gray_sync to Gray(17) with rbin=0 -> err_overflow=1 next edge, and it stays 1 until reset_n=0.
REQ-040 Assert reset_n=0 mid-stream with rd_valid=1 -> all outputs are per REQ-031 immediately, without waiting for a clk_rcv edge.
